mlp_pingpong_buf_ctrl: RTL

//  Parametrised N-bank ping-pong buffer controller for MLP layer data between producer and consumer.

---
 rtl/mlp_pingpong_buf_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mlp_pingpong_buf_ctrl.sv
// N-bank ping-pong buffer controller: the producer fills one bank while the consumer drains another.
// Drives external 1-cycle-read bank SRAMs through one-hot enables, bank addresses and mux/demux selects.
module mlp_pingpong_buf_ctrl #(
   parameter int NBANK = 2,
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH),
   parameter int BW    = (NBANK > 2) ? $clog2(NBANK) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [AW:0]      cfg_len,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [NBANK-1:0] wr_en,
   output logic [AW-1:0]    write_addr,
   output logic [BW-1:0]    demux_sel,
   input  logic             rd_ready,
   output logic             rd_valid,
   output logic [NBANK-1:0] rd_en,
   output logic [AW-1:0]    read_addr,
   output logic [BW-1:0]    mux_sel,
   output logic             rd_data_valid,
   output logic             wr_frame_done,
   output logic             rd_frame_done,
   output logic [NBANK-1:0] bank_full
);

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FILLING,
      BANK_FULL,
      BANK_DRAINING
   } bank_state_e;

   localparam logic [AW:0]   LEN_MAX   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
   localparam logic [BW-1:0] LAST_BANK = BW'(NBANK - 1);

   bank_state_e   state_q [NBANK];
   bank_state_e   state_d [NBANK];
   logic [AW:0]   len_q   [NBANK];
   logic [BW-1:0] wb_q;
   logic [BW-1:0] rb_q;
   logic [AW-1:0] wcnt_q;
   logic [AW-1:0] rcnt_q;

   logic          clr;
   logic          wr_accept;
   logic          rd_fire;
   logic          wr_last;
   logic          rd_last;
   logic [AW:0]   cfg_len_sat;
   logic [AW:0]   wr_len;

   // Pointer wrap is explicit so non-power-of-2 bank counts cycle correctly.
   function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
      return (b == LAST_BANK) ? '0 : b + BW'(1);
   endfunction

   assign clr = rst | flush;

   always_comb begin
      for (int i = 0; i < NBANK; i++) begin
         bank_full[i] = (state_q[i] == BANK_FULL) || (state_q[i] == BANK_DRAINING);
      end
   end

   assign wr_ready  = !clr && !bank_full[wb_q];
   assign wr_accept = wr_valid && wr_ready;
   assign rd_valid  = !clr && bank_full[rb_q];
   assign rd_fire   = rd_valid && rd_ready;

   assign write_addr = wcnt_q;
   assign read_addr  = rcnt_q;
   assign demux_sel  = wb_q;

   // The first word of a frame ends it already when the sampled length is one.
   always_comb begin
      cfg_len_sat = cfg_len;
      if (cfg_len == '0 || cfg_len > LEN_MAX) cfg_len_sat = LEN_MAX;
      wr_len  = (wcnt_q == '0) ? cfg_len_sat : len_q[wb_q];
      wr_last = wr_accept && ({1'b0, wcnt_q} == wr_len - LEN_ONE);
      rd_last = rd_fire && ({1'b0, rcnt_q} == len_q[rb_q] - LEN_ONE);
   end

   // NOTE: every signal driven in an always_comb gets its default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_en        = '0;
      rd_en        = '0;
      wr_en[wb_q]  = wr_accept;
      rd_en[rb_q]  = rd_fire;
   end

   // A bank is never written and read in the same cycle: writing needs it not full, reading needs it full.
   always_comb begin
      for (int i = 0; i < NBANK; i++) begin
         state_d[i] = state_q[i];
         if (wr_accept && wb_q == BW'(i)) begin
            if (wr_last) state_d[i] = BANK_FULL;
            else         state_d[i] = BANK_FILLING;
         end
         if (rd_fire && rb_q == BW'(i)) begin
            if (rd_last) state_d[i] = BANK_EMPTY;
            else         state_d[i] = BANK_DRAINING;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < NBANK; i++) state_q[i] <= BANK_EMPTY;
      end else begin
         for (int i = 0; i < NBANK; i++) state_q[i] <= state_d[i];
      end
   end

   // NOTE: len_q is a small flop array, not a RAM, so it is reset like any other state.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < NBANK; i++) len_q[i] <= LEN_MAX;
      end else if (wr_accept && wcnt_q == '0) begin
         len_q[wb_q] <= cfg_len_sat;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wb_q   <= '0;
         wcnt_q <= '0;
      end else if (wr_accept) begin
         if (wr_last) begin
            wb_q   <= next_bank(wb_q);
            wcnt_q <= '0;
         end else begin
            wcnt_q <= wcnt_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         rb_q   <= '0;
         rcnt_q <= '0;
      end else if (rd_fire) begin
         if (rd_last) begin
            rb_q   <= next_bank(rb_q);
            rcnt_q <= '0;
         end else begin
            rcnt_q <= rcnt_q + AW'(1);
         end
      end
   end

   // Read-side selects are delayed one cycle to line up with the SRAM read data.
   always_ff @(posedge clk) begin
      if (clr) begin
         mux_sel       <= '0;
         rd_data_valid <= 1'b0;
         wr_frame_done <= 1'b0;
         rd_frame_done <= 1'b0;
      end else begin
         mux_sel       <= rb_q;
         rd_data_valid <= rd_fire;
         wr_frame_done <= wr_last;
         rd_frame_done <= rd_last;
      end
   end

endmodule
